// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the wait-stated data memory:
//   - default values of the memory parameters
//   - wait-counter width
//   - the access FSM state encoding
// -----------------------------------------------------------------------------
package data_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = 8;
    localparam int WAIT_DEF   = 0;

    // Wide enough for the largest supported wait value (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Word-addressed storage with a byte-lane write and a registered read.
// There is no reset: contents survive reset and start at zero through the
// declaration initialiser.
//
// Ports:
//   clk_i     in   clock
//   wr_en_i   in   write strobe; lanes with be_i[i]=1 are updated
//   rd_en_i   in   read strobe; rdata_o loads mem[addr_i] at the edge
//   addr_i    in   word address (caller guarantees addr_i < DEPTH)
//   wdata_i   in   write data
//   be_i      in   byte enables
//   rdata_o   out  registered read data, holds until the next read
// -----------------------------------------------------------------------------
module data_mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                   clk_i,
    input  logic                   wr_en_i,
    input  logic                   rd_en_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [DATA_W/8-1:0]    be_i,
    output logic [DATA_W-1:0]      rdata_o
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ws.sv
// -----------------------------------------------------------------------------
// data_memory_ws
// Single-port data memory with a configurable number of wait states.
//
// Handshake: a request is accepted on a rising edge where req=1 and ready=1;
// addr/we/wdata/be are sampled at that edge. While ready=0 the requester must
// hold req and its inputs. Completion is signalled by ack for every cycle the
// FSM spends in DONE; rdata and err are valid only while ack=1 (err is forced
// to 0 otherwise). DONE also accepts a new request, so WAIT=0 sustains one
// access per cycle.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   access request
//   we       in   1 = write, 0 = read
//   addr     in   word address
//   wdata    in   write data
//   be       in   byte enables for writes
//   ready    out  can accept a request this cycle
//   ack      out  one-cycle completion pulse (held high for back-to-back)
//   rdata    out  read data, valid with ack, holds until the next read
//   err      out  completed access was out of range
// -----------------------------------------------------------------------------
module data_memory_ws
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WAIT   = WAIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [DATA_W/8-1:0]    be,
    output logic                   ready,
    output logic                   ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   err
);

    localparam int BE_W = DATA_W / 8;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                err_q;
    logic                rzero_q;   // rdata reads as zero (after reset or an out-of-range read)

    logic                accept;
    logic                exec;      // the access executes on this edge (edge entering DONE)
    logic                waiting;
    logic                op_we;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;
    logic [BE_W-1:0]     op_be;
    logic                in_range;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   arr_rdata;

    assign waiting = (state_q == WAIT_ST);
    assign ready   = !waiting;
    assign accept  = req && ready;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (WAIT > 0) begin
                        state_d = WAIT_ST;
                        cnt_d   = CNT_W'(WAIT - 1);
                    end else begin
                        state_d = DONE;
                        exec    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_ST: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With WAIT=0 the access executes on the accepting edge itself, before the
    // capture registers hold it, so the live inputs are used outside WAIT_ST.
    assign op_we    = waiting ? we_q    : we;
    assign op_addr  = waiting ? addr_q  : addr;
    assign op_wdata = waiting ? wdata_q : wdata;
    assign op_be    = waiting ? be_q    : be;

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    assign in_range = ({1'b0, op_addr} < (ADDR_W + 1)'(DEPTH));

    assign wr_en = exec && op_we && in_range;
    assign rd_en = exec && !op_we && in_range;

    // ---------------- state and capture registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rzero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            if (exec) begin
                err_q <= !in_range;
                // Writes leave rdata alone; reads pick array data or zero.
                if (!op_we) begin
                    rzero_q <= !in_range;
                end
            end
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .wr_en_i (wr_en),
        .rd_en_i (rd_en),
        .addr_i  (op_addr),
        .wdata_i (op_wdata),
        .be_i    (op_be),
        .rdata_o (arr_rdata)
    );

    assign ack   = (state_q == DONE);
    assign err   = ack && err_q;
    assign rdata = rzero_q ? '0 : arr_rdata;

endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws. Four instances cover the parameter sets:
//   0: DATA_W=8,  DEPTH=200, WAIT=0   (basic access, range error, back-to-back)
//   1: DATA_W=8,  DEPTH=256, WAIT=3   (wait-state timing)
//   2: DATA_W=8,  DEPTH=256, WAIT=2   (reset abort)
//   3: DATA_W=32, DEPTH=256, WAIT=0   (byte enables)
module tb_data_memory_ws;

  logic        clk = 1'b0;
  logic        rst_n [4];
  logic        req   [4];
  logic        we    [4];
  logic [7:0]  addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  be    [4];
  logic        ready [4];
  logic        ack   [4];
  logic        err   [4];
  logic [31:0] rdata [4];
  logic [7:0]  rd8   [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_memory_ws #(.DATA_W(8), .DEPTH(200), .ADDR_W(8), .WAIT(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0][7:0]), .be(be[0][0:0]), .ready(ready[0]), .ack(ack[0]),
    .rdata(rd8[0]), .err(err[0]));

  data_memory_ws #(.DATA_W(8), .DEPTH(256), .ADDR_W(8), .WAIT(3)) u_dut1 (
    .clk(clk), .reset_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1][7:0]), .be(be[1][0:0]), .ready(ready[1]), .ack(ack[1]),
    .rdata(rd8[1]), .err(err[1]));

  data_memory_ws #(.DATA_W(8), .DEPTH(256), .ADDR_W(8), .WAIT(2)) u_dut2 (
    .clk(clk), .reset_n(rst_n[2]), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2][7:0]), .be(be[2][0:0]), .ready(ready[2]), .ack(ack[2]),
    .rdata(rd8[2]), .err(err[2]));

  data_memory_ws #(.DATA_W(32), .DEPTH(256), .ADDR_W(8), .WAIT(0)) u_dut3 (
    .clk(clk), .reset_n(rst_n[3]), .req(req[3]), .we(we[3]), .addr(addr[3]),
    .wdata(wdata[3]), .be(be[3]), .ready(ready[3]), .ack(ack[3]),
    .rdata(rdata[3]), .err(err[3]));

  assign rdata[0] = {24'd0, rd8[0]};
  assign rdata[1] = {24'd0, rd8[1]};
  assign rdata[2] = {24'd0, rd8[2]};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access: drive at negedge, wait for ready, let the edge accept,
  // drop req, then count negedges until ack. lat = cycles from accept to ack,
  // nrdy = cycles with ready=0 before ack.
  task automatic access(input int k, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output logic e,
                        output int lat, output int nrdy);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    for (int i = 0; i < 50 && !ready[k]; i++) @(negedge clk);
    @(posedge clk);
    #1;
    req[k] = 1'b0;
    lat = 0;
    nrdy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (ack[k]) break;
      if (!ready[k]) nrdy++;
    end
    rd = rdata[k];
    e = err[k];
    check_val("ack_seen", {31'd0, ack[k]}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat, nrdy;

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0;
      wdata[k] = '0; be[k] = '0;
    end

    // ---------------- reset values ----------------
    #12;
    for (int k = 0; k < 4; k++) begin
      check_val("rst_ready", {31'd0, ready[k]}, 32'd1);
      check_val("rst_ack",   {31'd0, ack[k]},   32'd0);
      check_val("rst_err",   {31'd0, err[k]},   32'd0);
      check_val("rst_rdata", rdata[k],          32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;

    // ---------------- WAIT=0 write then read ----------------
    access(0, 1'b1, 8'h10, 32'hA5, 4'h1, rd, e, lat, nrdy);
    check_val("w0_lat", lat, 1);
    check_val("w0_err", {31'd0, e}, 0);
    access(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("r0_lat", lat, 1);
    check_val("r0_data", rd, 32'hA5);
    check_val("r0_err", {31'd0, e}, 0);
    // Write completion must not disturb rdata.
    access(0, 1'b1, 8'h11, 32'h33, 4'h1, rd, e, lat, nrdy);
    check_val("w_keeps_rdata", rd, 32'hA5);

    // ---------------- out-of-range (DEPTH=200) ----------------
    access(0, 1'b1, 8'd10, 32'h3C, 4'h1, rd, e, lat, nrdy);
    access(0, 1'b1, 8'd210, 32'h5A, 4'h1, rd, e, lat, nrdy);
    check_val("oor_w_err", {31'd0, e}, 1);
    check_val("oor_w_lat", lat, 1);
    @(negedge clk);
    check_val("err_idle", {31'd0, err[0]}, 0);
    access(0, 1'b0, 8'd210, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("oor_r_err", {31'd0, e}, 1);
    check_val("oor_r_data", rd, 32'h0);
    access(0, 1'b0, 8'd10, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("alias_data", rd, 32'h3C);
    check_val("alias_err", {31'd0, e}, 0);

    // ---------------- back-to-back reads, WAIT=0 ----------------
    for (int i = 0; i < 4; i++)
      access(0, 1'b1, 8'(i), 32'h80 + 32'(i), 4'h1, rd, e, lat, nrdy);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) addr[0] = 8'(i + 1);
      else req[0] = 1'b0;
      @(negedge clk);
      check_val("b2b_ack", {31'd0, ack[0]}, 1);
      check_val("b2b_data", rdata[0], 32'h80 + 32'(i));
    end
    @(negedge clk);
    check_val("b2b_ack_drop", {31'd0, ack[0]}, 0);

    // ---------------- byte enables, DATA_W=32 ----------------
    access(3, 1'b1, 8'd5, 32'h11223344, 4'b1111, rd, e, lat, nrdy);
    access(3, 1'b1, 8'd5, 32'hAABBCCDD, 4'b0101, rd, e, lat, nrdy);
    access(3, 1'b0, 8'd5, 32'h0, 4'b0000, rd, e, lat, nrdy);
    check_val("be_merge", rd, 32'h11BB33DD);
    access(3, 1'b1, 8'd5, 32'hFFFFFFFF, 4'b0000, rd, e, lat, nrdy);
    check_val("be0_err", {31'd0, e}, 0);
    access(3, 1'b0, 8'd5, 32'h0, 4'b0000, rd, e, lat, nrdy);
    check_val("be0_keep", rd, 32'h11BB33DD);

    // ---------------- WAIT=3 timing ----------------
    access(1, 1'b0, 8'h00, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("w3_lat", lat, 4);
    check_val("w3_notready", nrdy, 3);
    check_val("w3_data", rd, 32'h0);
    access(1, 1'b1, 8'h07, 32'h9C, 4'h1, rd, e, lat, nrdy);
    access(1, 1'b0, 8'h07, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("w3_rd_lat", lat, 4);
    check_val("w3_rd_data", rd, 32'h9C);

    // ---------------- reset abort, WAIT=2 ----------------
    access(2, 1'b1, 8'd5, 32'h42, 4'h1, rd, e, lat, nrdy);
    check_val("w2_lat", lat, 3);
    access(2, 1'b0, 8'd5, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("w2_data", rd, 32'h42);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 8'd3; wdata[2] = 32'h77; be[2] = 4'h1;
    @(posedge clk);
    #1;
    req[2] = 1'b0;
    @(negedge clk);
    check_val("abort_in_wait", {31'd0, ready[2]}, 0);
    rst_n[2] = 1'b0;
    #1;
    check_val("abort_ack", {31'd0, ack[2]}, 0);
    check_val("abort_err", {31'd0, err[2]}, 0);
    check_val("abort_rdata", rdata[2], 32'h0);
    check_val("abort_ready", {31'd0, ready[2]}, 1);
    @(negedge clk);
    rst_n[2] = 1'b1;
    access(2, 1'b0, 8'd3, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("abort_nowrite", rd, 32'h0);
    access(2, 1'b0, 8'd5, 32'h0, 4'h0, rd, e, lat, nrdy);
    check_val("rst_keeps_mem", rd, 32'h42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256: number of words; need not be a power of 2.
REQ-003 Parameter ADDR_W, default 8: address width; SHALL satisfy 2^ADDR_W >= DEPTH.
REQ-004 Parameter WAIT, default 0: wait states inserted between request acceptance and completion, range 0..15.
REQ-005 Localparam BE_W = DATA_W/8: byte-enable width.
REQ-006 Clocking: one clock, clk; reset is asynchronous and active-low, reset_n.
REQ-007 Port list, in order:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  access request
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- be  in  BE_W  byte enables for writes
- ready  out  1  can accept a request this cycle
- ack  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid with ack
- err  out  1  completed access was out of range

Function
REQ-008 FSM states SHALL be IDLE, WAIT_ST and DONE.
REQ-009 ready SHALL be 1 in IDLE and DONE, and 0 in WAIT_ST.
REQ-010 A request SHALL be accepted on a rising edge where req=1 and ready=1; addr, we, wdata and be SHALL be captured at that edge.
REQ-011 req while ready=0 SHALL be ignored; the requester holds req and inputs until accepted.
REQ-012 On acceptance, the next state SHALL be WAIT_ST with the counter loaded to WAIT-1 if WAIT>0; otherwise DONE.
REQ-013 In WAIT_ST the counter SHALL decrement each cycle; at count 0 the next state SHALL be DONE.
REQ-014 On the edge that enters DONE, the access SHALL execute:
- write: only lanes with be[i]=1 updated
- read: rdata registered from the array
REQ-015 ack SHALL be 1 for exactly the cycles spent in DONE.
REQ-016 Latency SHALL be WAIT+1 cycles from the accepting edge to ack=1.
REQ-017 In DONE, req=1 SHALL be accepted; back-to-back accesses with WAIT=0 SHALL sustain one access per cycle with ack held high.
REQ-018 In DONE with req=0, the next state SHALL be IDLE.
REQ-019 rdata SHALL hold its last read value until the next read completes.
REQ-020 Write completion SHALL leave rdata unchanged.
REQ-021 If the captured addr >= DEPTH:
- the access SHALL complete with normal timing and err=1 with ack
- no array bit SHALL change
- a read SHALL return rdata = 0
REQ-022 err SHALL be 0 whenever ack=0.
REQ-023 A read immediately following a write to the same address SHALL return the newly written bytes merged with the unwritten old bytes.
REQ-024 be=0 on a write SHALL complete with ack and no array change.

Reset
REQ-025 reset_n=0 SHALL asynchronously force:
- state = IDLE, counter = 0
- ack = 0, err = 0, rdata = 0
- ready = 1 immediately after reset
REQ-026 Reset during WAIT_ST SHALL abort the pending access; an aborted write SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be affected by reset.
REQ-028 Array contents SHALL be zero at time zero, via a simulation initialiser.

Structure
REQ-029 Shared package data_mem_pkg SHALL hold the state enum and the default values of DATA_W, DEPTH and WAIT.
REQ-030 Storage SHALL be the sub-module data_mem_array:
- synchronous byte-enable write
- registered read
- no reset
REQ-031 data_memory_ws SHALL contain only the FSM, wait counter, request capture and range check.

Verification
REQ-032 WAIT=0, DATA_W=8: write 0xA5 to addr 0x10, then read 0x10 -> ack one cycle after each acceptance; rdata=0xA5; err=0.
REQ-033 WAIT=3: read addr 0x00 after reset -> ready=0 for 3 cycles; ack on cycle 4; rdata=0x00.
REQ-034 DATA_W=32: write 0x11223344 with be=1111 to addr 5, then 0xAABBCCDD with be=0101, then read 5 -> rdata=0x11BB33DD.
REQ-035 DEPTH=200: write to addr 210, then read 210 -> ack with err=1; rdata=0; a read of addr 210 mod 200 (=10) is unchanged.
REQ-036 WAIT=2: write 0x77 to addr 3; assert reset_n=0 in WAIT_ST; release; read addr 3 -> rdata=0x00; ack/err/rdata were 0 during reset.
REQ-037 WAIT=0: four back-to-back reads of addresses 0..3 with req held high -> ack high for 4 consecutive cycles; rdata shows each word in order.
